// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU response unit: function codes and the
// response record carried through the FIFO.
package alu_pkg;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_NOT = 3'b010;
    localparam logic [2:0] F_AND = 3'b011;
    localparam logic [2:0] F_OR  = 3'b100;
    localparam logic [2:0] F_XOR = 3'b101;
    localparam logic [2:0] F_SLT = 3'b110;
    localparam logic [2:0] F_EQ  = 3'b111;

    typedef struct packed {
        logic [3:0] y;
        logic       zf;
        logic       of;
        logic       cf;
    } alu_rsp_t;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU: operands and function code in, result and
// flags out. For sub, cf is the signed less-than result rather than a borrow.
module alu4_core
    import alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [2:0] f_i,
    output alu_rsp_t   rsp_o
);

    logic [4:0] sum;
    logic [3:0] diff;
    logic       lt;
    logic [3:0] y;
    logic       of;
    logic       cf;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = a_i - b_i;
    assign lt   = $signed(a_i) < $signed(b_i);

    always_comb begin
        y  = 4'd0;
        of = 1'b0;
        cf = 1'b0;
        case (f_i)
            F_ADD: begin
                y  = sum[3:0];
                cf = sum[4];
                of = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
            end
            F_SUB: begin
                y  = diff;
                cf = lt;
                of = (a_i[3] != b_i[3]) && (diff[3] != a_i[3]);
            end
            F_NOT:   y = ~a_i;
            F_AND:   y = a_i & b_i;
            F_OR:    y = a_i | b_i;
            F_XOR:   y = a_i ^ b_i;
            F_SLT:   y = {3'b000, lt};
            F_EQ:    y = {3'b000, (a_i == b_i)};
            default: y = 4'd0;
        endcase
    end

    assign rsp_o.y  = y;
    assign rsp_o.zf = (y == 4'd0);
    assign rsp_o.of = of;
    assign rsp_o.cf = cf;

endmodule

// File: rtl/alu_resp.sv
// ALU request/response unit: each accepted operation is computed immediately
// and queued in a 2-entry response FIFO; also counts accepted requests.
module alu_resp
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] f,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] y,
    output logic       zf,
    output logic       of,
    output logic       cf,
    output logic [7:0] op_cnt
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; ready depends only on registered count, never on rsp_ready.
    alu_rsp_t   mem_q [DEPTH];
    alu_rsp_t   core_rsp;
    alu_rsp_t   head;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] op_cnt_q, op_cnt_d;
    logic       accept;
    logic       pop;

    alu4_core u_core (
        .a_i   (a),
        .b_i   (b),
        .f_i   (f),
        .rsp_o (core_rsp)
    );

    assign req_ready = (cnt_q != FULL_CNT);
    assign rsp_valid = (cnt_q != 2'd0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        wr_ptr_d = accept ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        op_cnt_d = (accept && (op_cnt_q != 8'hFF)) ? op_cnt_q + 8'd1 : op_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            op_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    // Storage is left unreset; stale entries are invisible once count is 0.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= core_rsp;
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign y      = head.y;
    assign zf     = head.zf;
    assign of     = head.of;
    assign cf     = head.cf;
    assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_alu_resp.sv
// Bench for alu_resp: behavioural queue model plus directed literal checks,
// then an exhaustive randomized-timing sweep of every a/b/f combination.
module tb_alu_resp;

  localparam int RW = 7;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] f;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] y;
  logic       zf;
  logic       of;
  logic       cf;
  logic [7:0] op_cnt;

  alu_resp #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .f         (f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .y         (y),
    .zf        (zf),
    .of        (of),
    .cf        (cf),
    .op_cnt    (op_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 0;
  bit rand_rsp = 0;

  logic [RW-1:0] exp_q[$];
  int            exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from arithmetic meaning: signed range overflow, unsigned carry.
  function automatic logic [RW-1:0] model_alu(input logic [3:0] ma, input logic [3:0] mb,
                                              input logic [2:0] mf);
    int ua, ub, sa, sb, r, s;
    logic [3:0] ry;
    logic rof, rcf;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    rof = 1'b0;
    rcf = 1'b0;
    case (mf)
      3'd0: begin r = ua + ub; ry = 4'(r % 16); rcf = (r >= 16);
                  s = sa + sb; rof = (s > 7) || (s < -8); end
      3'd1: begin r = (ua - ub + 16) % 16; ry = 4'(r); rcf = (sa < sb);
                  s = sa - sb; rof = (s > 7) || (s < -8); end
      3'd2: ry = 4'(15 - ua);
      3'd3: ry = ma & mb;
      3'd4: ry = ma | mb;
      3'd5: ry = ma ^ mb;
      3'd6: ry = (sa < sb) ? 4'd1 : 4'd0;
      default: ry = (ua == ub) ? 4'd1 : 4'd0;
    endcase
    return {ry, (ry == 4'd0), rof, rcf};
  endfunction

  // ---------------- model update ----------------
  always @(posedge clk) begin
    bit acc, pop;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      acc = req_valid && (exp_q.size() < 2);
      pop = (exp_q.size() > 0) && rsp_ready;
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(model_alu(a, b, f));
        if (exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
      check("req_ready", 32'(req_ready), 32'(exp_q.size() < 2));
      check("op_cnt", 32'(op_cnt), 32'(exp_cnt));
      if (exp_q.size() != 0 && rsp_valid)
        check("head_rsp", 32'({y, zf, of, cf}), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
    if (rand_rsp) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] tf);
    int waited = 0;
    a = ta;
    b = tb;
    f = tf;
    req_valid = 1'b1;
    while (exp_q.size() >= 2 && waited < 50) begin
      step();
      waited++;
    end
    if (waited >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no slot expected accept within 50 cycles");
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    a = '0;
    b = '0;
    f = '0;

    // Pin the model against hand-computed values.
    check("model_add_7_1", 32'(model_alu(4'd7, 4'd1, 3'd0)), 32'(7'b1000_010));
    check("model_sub_m8_1", 32'(model_alu(4'b1000, 4'd1, 3'd1)), 32'(7'b0111_011));
    check("model_sub_3_3", 32'(model_alu(4'd3, 4'd3, 3'd1)), 32'(7'b0000_100));
    check("model_slt_m1_0", 32'(model_alu(4'hF, 4'd0, 3'd6)), 32'(7'b0001_000));

    do_reset();
    check_en = 1;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_op_cnt", 32'(op_cnt), 32'd0);
    step();

    // Add 7+1: signed overflow, no carry.
    rsp_ready = 1'b1;
    send(4'd7, 4'd1, 3'd0);
    @(negedge clk);
    check("add_7_1", 32'({rsp_valid, y, zf, of, cf}), 32'(8'b1_1000_010));
    step();

    // Sub -8-1 and 3-3.
    send(4'b1000, 4'd1, 3'd1);
    @(negedge clk);
    check("sub_m8_1", 32'({rsp_valid, y, zf, of, cf}), 32'(8'b1_0111_011));
    step();
    send(4'd3, 4'd3, 3'd1);
    @(negedge clk);
    check("sub_3_3", 32'({rsp_valid, y, zf, of, cf}), 32'(8'b1_0000_100));
    step();
    step();

    // Backpressure: three back-to-back requests with consumer stalled.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    a = 4'd1; b = 4'd2; f = 3'd0;
    step();
    a = 4'd5; b = 4'd3; f = 3'd5;
    step();
    a = 4'd9; b = 4'd9; f = 3'd7;
    @(negedge clk);
    check("bp_full_ready", 32'(req_ready), 32'd0);
    check("bp_head_y", 32'(y), 32'd3);
    step();
    step();
    @(negedge clk);
    check("bp_hold_y", 32'(y), 32'd3);
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_second_y", 32'({req_ready, y}), 32'(5'b1_0110));
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_third_y", 32'({rsp_valid, y}), 32'(5'b1_0001));
    step();
    step();

    // Throughput: hold one entry, stream requests with consumer always ready.
    send(4'd2, 4'd2, 3'd4);
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      f = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("tp_steady", 32'({rsp_valid, req_ready}), 32'd3);
      step();
    end
    req_valid = 1'b0;
    step();
    step();

    // Reset while full, with a request pending.
    rsp_ready = 1'b0;
    send(4'd1, 4'd2, 3'd0);
    send(4'd3, 4'd4, 3'd4);
    req_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'({rsp_valid, req_ready, op_cnt}), 32'({2'b01, 8'd0}));
    step();

    // Exhaustive sweep with random gaps and random consumer backpressure.
    rand_rsp = 1;
    for (int fi = 0; fi < 8; fi++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++) begin
          if ($urandom_range(0, 3) == 0) step();
          send(4'(ai), 4'(bi), 3'(fi));
        end
    rand_rsp = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    check("sat_op_cnt", 32'(op_cnt), 32'd255);
    check("drained", 32'(rsp_valid), 32'd0);
    step();

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
